// File: rtl/multdiv_pkg.sv
// multdiv shared types: FSM encoding and default sizing.
// Imported by the sequencer, its step counter and the port interface users.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MULT = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Start/operand/result bundle between execute stage and multdiv unit.
// master = execute stage, slave = multdiv_sequencer.
interface multdiv_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT,
    output ctrl_DIV,
    output data_operandA,
    output data_operandB,
    input  data_result,
    input  data_exception,
    input  data_resultRDY,
    input  busy
  );

  modport slave (
    input  ctrl_MULT,
    input  ctrl_DIV,
    input  data_operandA,
    input  data_operandB,
    output data_result,
    output data_exception,
    output data_resultRDY,
    output busy
  );

endinterface

// File: rtl/multdiv_step_counter.sv
// Step counter for the iterative multdiv datapath.
// Flags the final step; clear wins over enable.
module multdiv_step_counter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign term = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit.
// Works on magnitudes; sign and overflow fixed up on the last step.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                clock,
  input logic                reset,
  multdiv_sequencer_if.slave bus
);

  localparam int W = WIDTH;

  state_e state, state_n;

  logic start, stepping, term, finish;

  // hi/lo: product {hi,lo} for multiply, {remainder,quotient} for divide
  logic [W:0]   opd;
  logic [W:0]   hi;
  logic [W-1:0] lo;
  logic         neg;
  logic         bzero;

  logic [W:0]   a_ext, b_ext, a_mag, b_mag;

  logic [W:0]   add_m, sum_m;
  logic [W:0]   m_hi_n;
  logic [W-1:0] m_lo_n;

  logic [W:0]   sh_d;
  logic [W+1:0] diff_d;
  logic         ge_d;
  logic [W:0]   d_hi_n;
  logic [W-1:0] d_lo_n;

  logic [W:0]   hi_n;
  logic [W-1:0] lo_n;

  logic [2*W-1:0] prod, lim;
  logic [W-1:0]   pm, qm;
  logic [W-1:0]   res_n;
  logic           exc_n;

  assign start    = bus.ctrl_MULT | bus.ctrl_DIV;
  assign stepping = (state == MULT) | (state == DIV);
  assign finish   = stepping & term & ~start;

  multdiv_step_counter #(
    .WIDTH (W),
    .CW    ($clog2(W))
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (start),
    .en    (stepping),
    .term  (term)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    priority case (1'b1)
      bus.ctrl_MULT: state_n = MULT;
      bus.ctrl_DIV:  state_n = DIV;
      default: begin
        unique case (state)
          IDLE:     state_n = IDLE;
          MULT,
          DIV:      state_n = term ? DONE : state;
          DONE:     state_n = IDLE;
          default:  state_n = IDLE;
        endcase
      end
    endcase
  end

  always_comb begin
    a_ext = {bus.data_operandA[W-1], bus.data_operandA};
    b_ext = {bus.data_operandB[W-1], bus.data_operandB};
    a_mag = a_ext[W] ? -a_ext : a_ext;
    b_mag = b_ext[W] ? -b_ext : b_ext;
  end

  always_comb begin
    add_m  = lo[0] ? opd : '0;
    sum_m  = hi + add_m;
    m_hi_n = {1'b0, sum_m[W:1]};
    m_lo_n = {sum_m[0], lo[W-1:1]};
  end

  always_comb begin
    sh_d   = {hi[W-1:0], lo[W-1]};
    diff_d = {1'b0, sh_d} - {1'b0, opd};
    ge_d   = ~diff_d[W+1];
    d_hi_n = ge_d ? diff_d[W:0] : sh_d;
    d_lo_n = {lo[W-2:0], ge_d};
  end

  assign hi_n = (state == DIV) ? d_hi_n : m_hi_n;
  assign lo_n = (state == DIV) ? d_lo_n : m_lo_n;

  always_comb begin
    prod  = {m_hi_n[W-1:0], m_lo_n};
    lim   = '0;
    lim[W-1] = 1'b1;
    pm    = m_lo_n;
    qm    = d_lo_n;
    res_n = '0;
    exc_n = 1'b0;
    if (state == DIV) begin
      exc_n = bzero | (~neg & qm[W-1]);
      if (!bzero)
        res_n = neg ? -qm : qm;
    end else begin
      exc_n = neg ? (prod > lim) : (prod >= lim);
      res_n = neg ? -pm : pm;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      opd                <= '0;
      hi                 <= '0;
      lo                 <= '0;
      neg                <= 1'b0;
      bzero              <= 1'b0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
    end else if (start) begin
      opd   <= bus.ctrl_MULT ? a_mag : b_mag;
      hi    <= '0;
      lo    <= bus.ctrl_MULT ? b_mag[W-1:0]
                             : a_mag[W-1:0];
      neg   <= bus.data_operandA[W-1]
             ^ bus.data_operandB[W-1];
      bzero <= (bus.data_operandB == '0);
    end else if (stepping) begin
      hi <= hi_n;
      lo <= lo_n;
      if (finish) begin
        bus.data_result    <= res_n;
        bus.data_exception <= exc_n;
      end
    end
  end

  assign bus.data_resultRDY = (state == DONE);
  assign bus.busy           = (state != IDLE);

endmodule
